// File: rtl/frame_dispatch_scheduler.sv
// frame_dispatch_scheduler: per-sample frame sequencer issuing block indices with windowed commit IDs.
// Optional saturating overrun counter is built only when FRAME_SCHED_OVERRUN_COUNT_EN is defined.
module frame_dispatch_scheduler #(
  parameter int n_blocks     = 256,
  parameter int max_inflight = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sample_tick,
  input  logic [$clog2(n_blocks):0]   n_active,
  input  logic [8:0]                  next_commit_id,
  input  logic                        issue_ready,
  output logic                        issue_valid,
  output logic [$clog2(n_blocks)-1:0] issue_block,
  output logic [8:0]                  issue_commit_id,
  output logic                        frame_busy,
  output logic                        frame_done,
  output logic                        overrun,
  output logic [15:0]                 overrun_count
);

  localparam int bw = $clog2(n_blocks);
  localparam logic [8:0]    window  = 9'(max_inflight);
  localparam logic [bw-1:0] blk_one = bw'(1);
  localparam logic [bw:0]   lim_one = (bw+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic [bw:0] lim;
  logic        pending;

  logic       xfer;
  logic       last_xfer;
  logic       tick_on;
  logic       busy_tick;
  logic       window_open;
  logic [8:0] inflight;
  logic [8:0] id_after;
  logic [8:0] inflight_after;

  // Window check looks at the ID count as it will stand after this cycle's transfer.
  always_comb begin
    xfer           = issue_valid && issue_ready;
    tick_on        = enable && sample_tick;
    busy_tick      = tick_on && (state != IDLE);
    inflight       = issue_commit_id - next_commit_id;
    id_after       = issue_commit_id + {8'd0, xfer};
    inflight_after = id_after - next_commit_id;
    window_open    = inflight_after < window;
    last_xfer      = xfer && (({1'b0, issue_block} + lim_one) == lim);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      lim             <= '0;
      pending         <= 1'b0;
      issue_valid     <= 1'b0;
      issue_block     <= '0;
      issue_commit_id <= '0;
      frame_busy      <= 1'b0;
      frame_done      <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= busy_tick;
      if (busy_tick) pending <= 1'b1;
      if (xfer) begin
        issue_block     <= issue_block + blk_one;
        issue_commit_id <= id_after;
      end
      case (state)
        IDLE: begin
          if (tick_on) begin
            state       <= ISSUE;
            lim         <= n_active;
            issue_block <= '0;
            frame_busy  <= 1'b1;
            issue_valid <= (n_active != '0) && window_open;
          end
        end
        ISSUE: begin
          if (last_xfer) begin
            state       <= DRAIN;
            issue_valid <= 1'b0;
          end else if (enable && (lim == '0)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
          end else if (!issue_valid || issue_ready) begin
            // A held request is never retracted; only a free slot is re-evaluated.
            issue_valid <= enable && !sample_tick && window_open;
          end
        end
        DRAIN: begin
          if (enable && (inflight == '0)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
          end
        end
        DONE: begin
          // A tick landing on the exit cycle starts the next frame rather than being lost.
          if (pending || tick_on) begin
            state       <= ISSUE;
            pending     <= 1'b0;
            lim         <= n_active;
            issue_block <= '0;
            frame_busy  <= 1'b1;
            issue_valid <= enable && (n_active != '0) && window_open;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_SCHED_OVERRUN_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_count <= '0;
    end else if (busy_tick && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_frame_dispatch_scheduler.sv
// Directed testbench for frame_dispatch_scheduler: frame issue, backpressure, overrun, wrap and window stall.
module tb_frame_dispatch_scheduler;

`ifdef FRAME_SCHED_OVERRUN_COUNT_EN
  localparam int cnt_step = 1;
`else
  localparam int cnt_step = 0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_tick;
  logic [8:0]  n_active;
  logic [8:0]  next_commit_id;
  logic        issue_ready;
  logic        issue_valid;
  logic [7:0]  issue_block;
  logic [8:0]  issue_commit_id;
  logic        frame_busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] overrun_count;

  logic        w_tick;
  logic [8:0]  w_n_active;
  logic [8:0]  w_nci;
  logic        w_ready;
  logic        w_valid;
  logic [7:0]  w_block;
  logic [8:0]  w_id;
  logic        w_busy;
  logic        w_done;
  logic        w_overrun;
  logic [15:0] w_count;

  int checks = 0;
  int errors = 0;

  frame_dispatch_scheduler #(.n_blocks(256), .max_inflight(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .n_active(n_active), .next_commit_id(next_commit_id), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_block(issue_block), .issue_commit_id(issue_commit_id),
    .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
    .overrun_count(overrun_count)
  );

  frame_dispatch_scheduler #(.n_blocks(256), .max_inflight(2)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .sample_tick(w_tick),
    .n_active(w_n_active), .next_commit_id(w_nci), .issue_ready(w_ready),
    .issue_valid(w_valid), .issue_block(w_block), .issue_commit_id(w_id),
    .frame_busy(w_busy), .frame_done(w_done), .overrun(w_overrun),
    .overrun_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges, leaving the bench at a falling edge for sampling and driving.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [8:0] wrap_ids [4];
    int         preset_sizes [2];
    logic       seen_done;
    logic       prev_x;

    wrap_ids     = '{9'd510, 9'd511, 9'd0, 9'd1};
    preset_sizes = '{256, 254};

    reset = 1'b0; enable = 1'b0; sample_tick = 1'b0; n_active = '0;
    next_commit_id = '0; issue_ready = 1'b0;
    w_tick = 1'b0; w_n_active = 9'd5; w_nci = '0; w_ready = 1'b1;
    @(negedge clk);
    applyStimulus(2);
    checkOutput("rst_valid", issue_valid, 0);
    checkOutput("rst_block", issue_block, 0);
    checkOutput("rst_id", issue_commit_id, 0);
    checkOutput("rst_busy", frame_busy, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_count", overrun_count, 0);

    $display("[TB] basic frame");
    reset = 1'b1; enable = 1'b1; issue_ready = 1'b1;
    n_active = 9'd4; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      next_commit_id = (c < 4) ? 9'd0 : ((c >= 7) ? 9'd4 : 9'(c - 3));
      if (c <= 4) begin
        checkOutput($sformatf("basic_valid_c%0d", c), issue_valid, 1);
        checkOutput($sformatf("basic_block_c%0d", c), issue_block, c - 1);
        checkOutput($sformatf("basic_id_c%0d", c), issue_commit_id, c - 1);
      end else begin
        checkOutput($sformatf("basic_valid_c%0d", c), issue_valid, 0);
      end
      checkOutput($sformatf("basic_busy_c%0d", c), frame_busy, (c <= 7) ? 1 : 0);
      checkOutput($sformatf("basic_done_c%0d", c), frame_done, (c == 8) ? 1 : 0);
      applyStimulus(1);
    end

    $display("[TB] backpressure and reset mid-issue");
    issue_ready = 1'b0; n_active = 9'd2; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("bp_valid_c%0d", c), issue_valid, 1);
      checkOutput($sformatf("bp_block_c%0d", c), issue_block, 0);
      checkOutput($sformatf("bp_id_c%0d", c), issue_commit_id, 4);
      applyStimulus(1);
    end
    issue_ready = 1'b1;
    checkOutput("bp_release_id", issue_commit_id, 4);
    applyStimulus(1);
    checkOutput("bp_after_block", issue_block, 1);
    checkOutput("bp_after_id", issue_commit_id, 5);
    checkOutput("bp_after_valid", issue_valid, 1);
    reset = 1'b0; next_commit_id = '0;
    applyStimulus(1);
    checkOutput("midrst_valid", issue_valid, 0);
    checkOutput("midrst_block", issue_block, 0);
    checkOutput("midrst_id", issue_commit_id, 0);
    checkOutput("midrst_busy", frame_busy, 0);
    checkOutput("midrst_done", frame_done, 0);
    checkOutput("midrst_overrun", overrun, 0);
    reset = 1'b1;

    $display("[TB] overrun during drain");
    n_active = 9'd2; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    checkOutput("ovr_id0", issue_commit_id, 0);
    applyStimulus(1);
    checkOutput("ovr_id1", issue_commit_id, 1);
    applyStimulus(1);
    checkOutput("ovr_drain_valid", issue_valid, 0);
    checkOutput("ovr_drain_busy", frame_busy, 1);
    sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    checkOutput("ovr_pulse1", overrun, 1);
    checkOutput("ovr_count1", overrun_count, cnt_step);
    applyStimulus(1);
    checkOutput("ovr_pulse1_end", overrun, 0);
    sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    checkOutput("ovr_pulse2", overrun, 1);
    checkOutput("ovr_count2", overrun_count, 2 * cnt_step);
    checkOutput("ovr_busy2", frame_busy, 1);
    applyStimulus(1);
    checkOutput("ovr_pulse2_end", overrun, 0);
    next_commit_id = 9'd2;
    applyStimulus(1);
    checkOutput("ovr_done1", frame_done, 1);
    checkOutput("ovr_done1_busy", frame_busy, 0);
    applyStimulus(1);
    checkOutput("ovr_next_valid", issue_valid, 1);
    checkOutput("ovr_next_block", issue_block, 0);
    checkOutput("ovr_next_id", issue_commit_id, 2);
    applyStimulus(1);
    checkOutput("ovr_next_block1", issue_block, 1);
    checkOutput("ovr_next_id1", issue_commit_id, 3);
    applyStimulus(1);
    next_commit_id = 9'd4;
    applyStimulus(1);
    checkOutput("ovr_done2", frame_done, 1);
    applyStimulus(1);
    checkOutput("ovr_idle_busy", frame_busy, 0);
    applyStimulus(1);
    checkOutput("ovr_no_extra_busy", frame_busy, 0);
    checkOutput("ovr_no_extra_done", frame_done, 0);

    $display("[TB] empty frame");
    n_active = 9'd0; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    checkOutput("empty_valid_t1", issue_valid, 0);
    checkOutput("empty_done_t1", frame_done, 0);
    applyStimulus(1);
    checkOutput("empty_done_t2", frame_done, 1);
    checkOutput("empty_valid_t2", issue_valid, 0);
    applyStimulus(1);
    checkOutput("empty_done_t3", frame_done, 0);
    checkOutput("empty_id", issue_commit_id, 4);

    $display("[TB] ticks ignored while disabled");
    enable = 1'b0; n_active = 9'd2; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    checkOutput("dis_busy", frame_busy, 0);
    checkOutput("dis_overrun", overrun, 0);
    checkOutput("dis_valid", issue_valid, 0);
    enable = 1'b1;

    $display("[TB] commit ID wrap");
    reset = 1'b0; next_commit_id = '0;
    applyStimulus(1);
    reset = 1'b1;
    for (int f = 0; f < 2; f++) begin
      n_active = 9'(preset_sizes[f]); sample_tick = 1'b1;
      applyStimulus(1);
      sample_tick = 1'b0;
      seen_done = 1'b0; prev_x = 1'b0;
      for (int k = 0; k < 400 && !seen_done; k++) begin
        if (prev_x) next_commit_id = next_commit_id + 9'd1;
        prev_x = issue_valid && issue_ready;
        applyStimulus(1);
        if (frame_done) seen_done = 1'b1;
      end
      checkOutput($sformatf("preset_done_f%0d", f), seen_done, 1);
      applyStimulus(1);
    end
    checkOutput("preset_id", issue_commit_id, 510);
    n_active = 9'd4; sample_tick = 1'b1;
    applyStimulus(1);
    sample_tick = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("wrap_valid_c%0d", c), issue_valid, 1);
      checkOutput($sformatf("wrap_id_c%0d", c), issue_commit_id, wrap_ids[c-1]);
      applyStimulus(1);
    end
    checkOutput("wrap_drain_busy", frame_busy, 1);
    applyStimulus(1);
    checkOutput("wrap_hold_busy", frame_busy, 1);
    next_commit_id = 9'd2;
    applyStimulus(1);
    checkOutput("wrap_done", frame_done, 1);

    $display("[TB] window stall");
    w_tick = 1'b1;
    applyStimulus(1);
    w_tick = 1'b0;
    checkOutput("win_valid_c1", w_valid, 1);
    checkOutput("win_id_c1", w_id, 0);
    applyStimulus(1);
    checkOutput("win_valid_c2", w_valid, 1);
    checkOutput("win_id_c2", w_id, 1);
    applyStimulus(1);
    checkOutput("win_stall_c3", w_valid, 0);
    checkOutput("win_id_c3", w_id, 2);
    applyStimulus(1);
    checkOutput("win_stall_c4", w_valid, 0);
    w_nci = 9'd1;
    applyStimulus(1);
    checkOutput("win_reassert", w_valid, 1);
    checkOutput("win_reassert_block", w_block, 2);
    applyStimulus(1);
    checkOutput("win_stall_again", w_valid, 0);
    checkOutput("win_id_final", w_id, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
